uart_tx_fifo: RTL

//   Buffered UART transmitter for the jacaranda-8 peripheral bus: 8N1, LSB first, no parity, no flow control.
//   CPU stores bytes into a small FIFO via memory-mapped writes on access_addr/reg_w_en.
//   A serializer drains the FIFO back-to-back onto tx; int_req signals "all queued bytes sent".

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_fifo_sync_fifo.sv | 53 +++++
 rtl/uart_tx_fifo.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the buffered UART transmitter: FSM encoding,
// bus register map, line defaults and a divisor helper.
package uart_pkg;

  localparam int unsigned DEFAULT_BAUD = 115200;
  localparam int unsigned FRAME_BITS   = 10;   // start + 8 data + stop

  localparam logic [7:0] ADDR_TX_DATA = 8'd250;
  localparam logic [7:0] ADDR_TX_ACK  = 8'd251;
  localparam logic [7:0] ADDR_TX_STAT = 8'd252;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // Clocks per bit; a clock slower than the line rate still gets one clock per bit.
  function automatic logic [31:0] calc_div(input logic [31:0] freq, input logic [31:0] baud);
    logic [31:0] d;
    d = freq / baud;
    return (d == 32'd0) ? 32'd1 : d;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Small synchronous FIFO with first-word-fall-through read data.
// Push while full and pop while empty are ignored.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign level_o = cnt_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage array; contents are meaningless while empty so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers wrap naturally (power-of-two depth); count tracks occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bus writes fill a FIFO, the serializer
// drains it back-to-back, int_req flags "everything sent".
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_RATE    = DEFAULT_BAUD,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [7:0]  TX_DATA_ADDR = ADDR_TX_DATA,
  parameter logic [7:0]  TX_ACK_ADDR  = ADDR_TX_ACK
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [31:0]                   clk_freq,
  input  logic [7:0]                    access_addr,
  input  logic                          reg_w_en,
  input  logic [7:0]                    w_data,
  output logic                          tx,
  output logic                          busy_flag,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          int_req
);

  logic [1:0]  state_q, state_d;
  logic [31:0] div_q, div_calc, cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        ovf_q, ovf_d, int_q, int_d;
  logic        push_req, ack_req, pop, frame_done;
  logic        fifo_empty;
  logic [7:0]  fifo_rdata;

  assign push_req = reg_w_en && (access_addr == TX_DATA_ADDR);
  assign ack_req  = reg_w_en && (access_addr == TX_ACK_ADDR);
  assign div_calc = calc_div(clk_freq, 32'(BAUD_RATE));

  sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_req),
    .pop_i   (pop),
    .wdata_i (w_data),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // Serializer next state: each of START/DATA/STOP holds the line for div clocks;
  // STOP chains straight into the next START when more bytes are queued.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    pop        = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rdata;
          cnt_d   = div_calc - 32'd1;   // div_q loads div_calc on this same edge
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (cnt_q == 32'd0) begin
          state_d = ST_DATA;
          bit_d   = 3'd0;
          cnt_d   = div_q - 32'd1;
        end else cnt_d = cnt_q - 32'd1;
      end
      ST_DATA: begin
        if (cnt_q == 32'd0) begin
          cnt_d = div_q - 32'd1;
          if (bit_q == 3'd7) state_d = ST_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else cnt_d = cnt_q - 32'd1;
      end
      default: begin
        if (cnt_q == 32'd0) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_rdata;
            cnt_d   = div_q - 32'd1;
            state_d = ST_START;
          end else begin
            state_d    = ST_IDLE;
            frame_done = 1'b1;
          end
        end else cnt_d = cnt_q - 32'd1;
      end
    endcase
  end

  // Line level derived from the next state so tx is a clean register output.
  always_comb begin
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[bit_d];
      default:  tx_d = 1'b1;
    endcase
  end

  // Sticky flags: a set in the same cycle as an ACK takes priority.
  always_comb begin
    int_d = int_q;
    ovf_d = ovf_q;
    if (ack_req) begin
      int_d = 1'b0;
      ovf_d = 1'b0;
    end
    if (frame_done && !push_req) int_d = 1'b1;
    if (push_req && fifo_full)   ovf_d = 1'b1;
  end

  // Serializer and flag registers; the divisor only follows clk_freq while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      div_q   <= 32'd1;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      int_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE) div_q <= div_calc;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      int_q   <= int_d;
      ovf_q   <= ovf_d;
    end
  end

  assign tx        = tx_q;
  assign busy_flag = (state_q != ST_IDLE) || !fifo_empty;
  assign overflow  = ovf_q;
  assign int_req   = int_q;

endmodule
